// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-side memory access unit: CU size/extend codes and FSM states.
package mem_access_unit_pkg;

  localparam logic [3:0] RAM_WE_N = 4'b0000;
  localparam logic [3:0] RAM_WE_B = 4'b0001;
  localparam logic [3:0] RAM_WE_H = 4'b0011;
  localparam logic [3:0] RAM_WE_W = 4'b1111;

  localparam logic [2:0] RAM_EXT_N  = 3'd0;
  localparam logic [2:0] RAM_EXT_B  = 3'd1;
  localparam logic [2:0] RAM_EXT_BU = 3'd2;
  localparam logic [2:0] RAM_EXT_H  = 3'd3;
  localparam logic [2:0] RAM_EXT_HU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Halfwords need an even address; words (and full-word loads) need word alignment.
  function automatic logic misaligned(input logic [3:0] we, input logic [2:0] ext,
                                      input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (we == RAM_WE_H) mis = off[0];
    else if (we == RAM_WE_W) mis = (off != 2'b00);
    else if (we == RAM_WE_N) begin
      if (ext == RAM_EXT_H || ext == RAM_EXT_HU) mis = off[0];
      else if (ext == RAM_EXT_N) mis = (off != 2'b00);
    end
    return mis;
  endfunction

  function automatic logic [31:0] lane_data(input logic [3:0] we, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (we == RAM_WE_B) r = {4{d[7:0]}};
    else if (we == RAM_WE_H) r = {2{d[15:0]}};
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Combinational load aligner: picks the addressed byte/halfword from a raw word and extends it.
module mem_access_unit_load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  ext_op,
  output logic [31:0] ext_word
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_sh = raw_word >> {offset, 3'b000};
    half_sh = raw_word >> {offset[1], 4'b0000};
    byte_v  = byte_sh[7:0];
    half_v  = half_sh[15:0];
    case (ext_op)
      RAM_EXT_B:  ext_word = {{24{byte_v[7]}}, byte_v};
      RAM_EXT_BU: ext_word = {24'h0, byte_v};
      RAM_EXT_H:  ext_word = {{16{half_v[15]}}, half_v};
      RAM_EXT_HU: ext_word = {16'h0, half_v};
      default:    ext_word = raw_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: runs one op on the data-RAM bus with addr_ok/data_ok handshake.
// Bus handshake: mem_req is held with stable fields until mem_addr_ok; mem_data_ok ends the op.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW         = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic          req_valid,
  input  logic [3:0]    ram_we,
  input  logic [2:0]    ram_ext_op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          resp_valid,
  output logic [31:0]   rdata,
  output logic          ale,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [31:0]   mem_rdata,
  output state_e        dbg_state
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    ext_q, ext_d;
  logic [1:0]    off_q, off_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ale_q, ale_d;
  logic          bus_err_q, bus_err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wr_q, mem_wr_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   load_word;
  logic          is_store;
  logic          mis;

  mem_access_unit_load_ext u_load_ext (
    .raw_word (mem_rdata),
    .offset   (off_q),
    .ext_op   (ext_q),
    .ext_word (load_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ext_d        = ext_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    ale_d        = 1'b0;
    bus_err_d    = 1'b0;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    stall        = 1'b0;
    is_store     = (ram_we != RAM_WE_N);
    mis          = misaligned(ram_we, ram_ext_op, addr[1:0]);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (mis) begin
            ale_d = 1'b1;
          end else begin
            stall       = ~cpu_rst;
            state_d     = ST_REQ;
            ext_d       = ram_ext_op;
            off_d       = addr[1:0];
            mem_req_d   = 1'b1;
            mem_wr_d    = is_store;
            mem_wstrb_d = is_store ? 4'(ram_we << addr[1:0]) : 4'b0000;
            mem_addr_d  = {addr[AW-1:2], 2'b00};
            mem_wdata_d = is_store ? lane_data(ram_we, wdata) : 32'h0;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (mem_data_ok) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            if (!mem_wr_q) rdata_d = load_word;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_data_ok) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          if (!mem_wr_q) rdata_d = load_word;
        end else if (cnt_q == LIMIT_M1) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      ext_q        <= RAM_EXT_N;
      off_q        <= 2'b00;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      ale_q        <= 1'b0;
      bus_err_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ext_q        <= ext_d;
      off_q        <= off_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      ale_q        <= ale_d;
      bus_err_q    <= bus_err_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign ale        = ale_q;
  assign bus_err    = bus_err_q;
  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, misalign, stretched handshake, timeout, reset.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid;
  logic [3:0]  ram_we;
  logic [2:0]  ram_ext_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, resp_valid, ale, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  state_e      dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 cpu_clk = ~cpu_clk;

  mem_access_unit #(.AW(32), .WAIT_LIMIT(4)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .req_valid   (req_valid),
    .ram_we      (ram_we),
    .ram_ext_op  (ram_ext_op),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .resp_valid  (resp_valid),
    .rdata       (rdata),
    .ale         (ale),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid  = 1'b0;
    ram_we     = RAM_WE_N;
    ram_ext_op = RAM_EXT_N;
    addr       = 32'h0;
    wdata      = 32'h0;
  endtask

  // Presents one request for a single cycle; aligned requests must stall combinationally.
  task automatic issue(input logic [3:0] we, input logic [2:0] ext, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid  = 1'b1;
    ram_we     = we;
    ram_ext_op = ext;
    addr       = a;
    wdata      = d;
    #1;
    chk("stall_on_accept", {31'h0, stall}, 32'd1);
    step();
    clear_req();
  endtask

  initial begin
    cpu_rst     = 1'b1;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    clear_req();
    step();
    step();
    cpu_rst = 1'b0;
    chk("rst_stall",      {31'h0, stall},      32'd0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_rdata",      rdata,               32'h0);
    chk("rst_ale",        {31'h0, ale},        32'd0);
    chk("rst_bus_err",    {31'h0, bus_err},    32'd0);
    chk("rst_mem_req",    {31'h0, mem_req},    32'd0);
    chk("rst_mem_wr",     {31'h0, mem_wr},     32'd0);
    chk("rst_wstrb",      {28'h0, mem_wstrb},  32'd0);
    chk("rst_mem_addr",   mem_addr,            32'h0);
    chk("rst_mem_wdata",  mem_wdata,           32'h0);

    // sw 0x100: addr_ok in first REQ cycle, data_ok two cycles later, resp_valid at cycle 4
    issue(RAM_WE_W, RAM_EXT_N, 32'h100, 32'hDEADBEEF);
    chk("sw_mem_req",   {31'h0, mem_req},   32'd1);
    chk("sw_mem_wr",    {31'h0, mem_wr},    32'd1);
    chk("sw_wstrb",     {28'h0, mem_wstrb}, 32'hF);
    chk("sw_mem_addr",  mem_addr,           32'h100);
    chk("sw_mem_wdata", mem_wdata,          32'hDEADBEEF);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    chk("sw_wait_req",   {31'h0, mem_req}, 32'd0);
    chk("sw_wait_stall", {31'h0, stall},   32'd1);
    step();
    mem_data_ok = 1'b1;
    step();
    mem_data_ok = 1'b0;
    chk("sw_resp_valid", {31'h0, resp_valid}, 32'd1);
    chk("sw_done_stall", {31'h0, stall},      32'd0);
    step();
    chk("sw_resp_pulse", {31'h0, resp_valid}, 32'd0);

    // sb 0x103: top byte lane, replicated data; addr_ok+data_ok together skip WAIT
    issue(RAM_WE_B, RAM_EXT_N, 32'h103, 32'h000000A5);
    chk("sb_wstrb",     {28'h0, mem_wstrb}, 32'h8);
    chk("sb_mem_wdata", mem_wdata,          32'hA5A5A5A5);
    chk("sb_mem_addr",  mem_addr,           32'h100);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    chk("sb_skip_resp", {31'h0, resp_valid}, 32'd1);
    step();

    // sh 0x102: upper half lanes
    issue(RAM_WE_H, RAM_EXT_N, 32'h102, 32'h00001234);
    chk("sh_wstrb",     {28'h0, mem_wstrb}, 32'hC);
    chk("sh_mem_wdata", mem_wdata,          32'h12341234);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    step();

    // ld.b 0x102 through WAIT: byte 0x80 sign-extends
    issue(RAM_WE_N, RAM_EXT_B, 32'h102, 32'h0);
    chk("ldb_mem_wr",   {31'h0, mem_wr},    32'd0);
    chk("ldb_wstrb",    {28'h0, mem_wstrb}, 32'h0);
    chk("ldb_mem_addr", mem_addr,           32'h100);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0080FF00;
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    chk("ldb_resp",  {31'h0, resp_valid}, 32'd1);
    chk("ldb_rdata", rdata,               32'hFFFFFF80);
    step();

    // ld.bu / ld.h / ld.hu, each through the skip-WAIT path
    issue(RAM_WE_N, RAM_EXT_BU, 32'h102, 32'h0);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0080FF00;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    chk("ldbu_rdata", rdata, 32'h00000080);
    step();
    issue(RAM_WE_N, RAM_EXT_H, 32'h100, 32'h0);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    chk("ldh_rdata", rdata, 32'hFFFFFF00);
    step();
    issue(RAM_WE_N, RAM_EXT_HU, 32'h100, 32'h0);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    chk("ldhu_rdata", rdata, 32'h0000FF00);
    step();

    // ld.h 0x101: misaligned, ale pulse, no bus cycle
    req_valid  = 1'b1;
    ram_ext_op = RAM_EXT_H;
    addr       = 32'h101;
    #1;
    chk("ale_no_stall", {31'h0, stall}, 32'd0);
    step();
    clear_req();
    chk("ale_pulse",  {31'h0, ale},     32'd1);
    chk("ale_no_req", {31'h0, mem_req}, 32'd0);
    step();
    chk("ale_clear",   {31'h0, ale},     32'd0);
    chk("ale_no_req2", {31'h0, mem_req}, 32'd0);

    // sw 0x102: misaligned store also raises ale
    req_valid = 1'b1;
    ram_we    = RAM_WE_W;
    addr      = 32'h102;
    step();
    clear_req();
    chk("ale_sw", {31'h0, ale}, 32'd1);
    chk("ale_sw_no_req", {31'h0, mem_req}, 32'd0);
    step();

    // ld.w 0x200 with addr_ok held low for 5 cycles
    issue(RAM_WE_N, RAM_EXT_N, 32'h200, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_mem_req",  {31'h0, mem_req}, 32'd1);
      chk("hold_mem_addr", mem_addr,         32'h200);
      chk("hold_stall",    {31'h0, stall},   32'd1);
      step();
    end
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    chk("ldw_resp",  {31'h0, resp_valid}, 32'd1);
    chk("ldw_rdata", rdata,               32'h12345678);
    step();

    // ld.w 0x300, data_ok never: bus_err four edges after addr_ok
    issue(RAM_WE_N, RAM_EXT_N, 32'h300, 32'h0);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_no_err", {31'h0, bus_err}, 32'd0);
      chk("to_stall",  {31'h0, stall},   32'd1);
      step();
    end
    chk("to_bus_err", {31'h0, bus_err},    32'd1);
    chk("to_no_resp", {31'h0, resp_valid}, 32'd0);
    chk("to_idle",    {31'h0, stall},      32'd0);
    step();
    chk("to_err_pulse", {31'h0, bus_err}, 32'd0);

    // cpu_rst during WAIT, then a late data_ok in IDLE
    issue(RAM_WE_N, RAM_EXT_N, 32'h400, 32'h0);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    step();
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
    chk("rstw_stall", {31'h0, stall},      32'd0);
    chk("rstw_req",   {31'h0, mem_req},    32'd0);
    chk("rstw_resp",  {31'h0, resp_valid}, 32'd0);
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFEF00D;
    step();
    mem_data_ok = 1'b0;
    chk("late_dok_resp",  {31'h0, resp_valid}, 32'd0);
    chk("late_dok_stall", {31'h0, stall},      32'd0);
    step();
    chk("late_dok_resp2", {31'h0, resp_valid}, 32'd0);
    chk("late_dok_rdata", rdata,               32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
